// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
// Receive-side checker for a VGA raster. Recovers active pixel coordinates,
// measures frame geometry against the expected mode, accumulates a per-frame
// R+G+B checksum over active pixels and captures the color at a probe point.
//
// Ports:
//   clk, rst                  system clock, async active-high reset
//   pix_en                    pixel strobe; all raster inputs sampled on it
//   hsync_n, vsync_n          active-low syncs
//   blank_n                   1 = active pixel
//   rgb[23:0]                 pixel color {R,G,B}
//   probe_x, probe_y          active-area coordinate to capture
//   rx_x, rx_y, rx_valid      coordinate of the last sample (registered)
//   h_total_meas              last line length in pixel strobes
//   v_total_meas              last frame length in lines
//   h_active_meas             max active pixels in any line of last frame
//   v_active_meas             lines with at least one active pixel
//   frame_sum                 R+G+B sum over active pixels of last frame
//   probe_rgb                 color captured at the probe in last frame
//   frame_done                one-cycle pulse when the frame outputs update
//   locked, geom_err          geometry verdict of the last completed frame
//
// state   | meaning
// --------+---------------------------------------------------------------
// SEARCH  | no frame start seen yet; outputs untouched
// MEASURE | measuring; last completed frame (if any) mismatched
// LOCKED  | measuring; last completed frame matched the expected geometry
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic        blank_n,
    input  logic [23:0] rgb,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_valid,
    output logic [10:0] h_total_meas,
    output logic [9:0]  v_total_meas,
    output logic [9:0]  h_active_meas,
    output logic [9:0]  v_active_meas,
    output logic [31:0] frame_sum,
    output logic [23:0] probe_rgb,
    output logic        frame_done,
    output logic        locked,
    output logic        geom_err
);

    localparam logic [10:0] HT_L = 11'(H_TOTAL);
    localparam logic [9:0]  VT_L = 10'(V_TOTAL);
    localparam logic [9:0]  HA_L = 10'(H_ACTIVE);
    localparam logic [9:0]  VA_L = 10'(V_ACTIVE);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    state_t      state, state_next;
    logic        frame_close;

    logic        prev_hs, prev_vs;
    logic [10:0] h_cnt, line_len;
    logic [9:0]  act_cnt, line_max, act_lines, v_cnt;
    logic [31:0] sum_acc;
    logic [23:0] probe_acc;

    logic        h_edge, v_edge;
    logic [10:0] line_len_f;
    logic [9:0]  max_f, act_lines_f, v_cnt_f;
    logic [9:0]  x_cur, y_cur;
    logic [9:0]  pix_sum;
    logic        probe_hit;
    logic        geom_ok;

    assign h_edge = pix_en & ~hsync_n & prev_hs;
    assign v_edge = pix_en & ~vsync_n & prev_vs;

    // "_f" values have the closing line's H-edge folded in, so a frame close
    // on a coincident H/V edge still sees the final line.
    assign line_len_f  = !h_edge ? line_len :
                         (h_cnt == 11'h7FF) ? 11'h7FF : h_cnt + 11'd1;
    assign max_f       = (h_edge && act_cnt > line_max) ? act_cnt : line_max;
    assign act_lines_f = (h_edge && act_cnt != 10'd0 && act_lines != 10'h3FF) ?
                         act_lines + 10'd1 : act_lines;
    assign v_cnt_f     = (h_edge && v_cnt != 10'h3FF) ? v_cnt + 10'd1 : v_cnt;

    // Coordinates of the current sample: a new line or frame starts at zero.
    assign x_cur = (h_edge || v_edge) ? 10'd0 : act_cnt;
    assign y_cur = v_edge ? 10'd0 : act_lines_f;

    assign pix_sum   = {2'b00, rgb[23:16]} + {2'b00, rgb[15:8]} + {2'b00, rgb[7:0]};
    assign probe_hit = blank_n && (x_cur == probe_x) && (y_cur == probe_y);
    assign geom_ok   = (line_len_f == HT_L) && (v_cnt_f == VT_L) &&
                       (max_f == HA_L) && (act_lines_f == VA_L);

    always_comb begin
        state_next  = state;
        frame_close = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (v_edge) state_next = ST_MEASURE;
            end
            ST_MEASURE, ST_LOCKED: begin
                if (v_edge) begin
                    frame_close = 1'b1;
                    state_next  = geom_ok ? ST_LOCKED : ST_MEASURE;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_SEARCH;
        else     state <= state_next;
    end

    // Sample-rate datapath; everything here freezes while pix_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_hs   <= 1'b1;
            prev_vs   <= 1'b1;
            h_cnt     <= '0;
            line_len  <= '0;
            act_cnt   <= '0;
            line_max  <= '0;
            act_lines <= '0;
            v_cnt     <= '0;
            sum_acc   <= '0;
            probe_acc <= '0;
            rx_x      <= '0;
            rx_y      <= '0;
            rx_valid  <= 1'b0;
        end else if (pix_en) begin
            prev_hs  <= hsync_n;
            prev_vs  <= vsync_n;
            h_cnt    <= h_edge ? 11'd0 :
                        (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;
            line_len <= line_len_f;
            act_cnt  <= (blank_n && x_cur != 10'h3FF) ? x_cur + 10'd1 : x_cur;
            rx_x     <= x_cur;
            rx_y     <= y_cur;
            rx_valid <= blank_n;
            if (v_edge) begin
                // The V-edge sample itself belongs to the new frame.
                v_cnt     <= '0;
                act_lines <= '0;
                line_max  <= '0;
                sum_acc   <= blank_n ? {22'd0, pix_sum} : 32'd0;
                probe_acc <= probe_hit ? rgb : 24'd0;
            end else begin
                v_cnt     <= v_cnt_f;
                act_lines <= act_lines_f;
                line_max  <= max_f;
                if (blank_n)   sum_acc   <= sum_acc + {22'd0, pix_sum};
                if (probe_hit) probe_acc <= rgb;
            end
        end
    end

    // Frame-level outputs; frame_done is a single clk pulse regardless of pix_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_total_meas  <= '0;
            v_total_meas  <= '0;
            h_active_meas <= '0;
            v_active_meas <= '0;
            frame_sum     <= '0;
            probe_rgb     <= '0;
            frame_done    <= 1'b0;
            locked        <= 1'b0;
            geom_err      <= 1'b0;
        end else begin
            frame_done <= frame_close;
            if (frame_close) begin
                h_total_meas  <= line_len_f;
                v_total_meas  <= v_cnt_f;
                h_active_meas <= max_f;
                v_active_meas <= act_lines_f;
                frame_sum     <= sum_acc;
                probe_rgb     <= probe_acc;
                locked        <= geom_ok;
                geom_err      <= ~geom_ok;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a reduced 16x12 active / 24x18 total
// raster so that many frames fit in a short run.
// Layout (line v, pixel h): vsync low on lines 0..1, active lines 3..14.
//   normal:     active h 0..15, hsync low h 18..21 (V-edge not on an H-edge)
//   coincident: active h 6..21, hsync low h 0..3  (V-edge on an H-edge)
module tb_vga_frame_monitor;

    localparam int HA = 16;
    localparam int VA = 12;
    localparam int HT = 24;
    localparam int VT = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync_n = 1'b1;
    logic        vsync_n = 1'b1;
    logic        blank_n = 1'b0;
    logic [23:0] rgb = '0;
    logic [9:0]  probe_x = '0;
    logic [9:0]  probe_y = '0;
    logic [9:0]  rx_x, rx_y;
    logic        rx_valid;
    logic [10:0] h_total_meas;
    logic [9:0]  v_total_meas, h_active_meas, v_active_meas;
    logic [31:0] frame_sum;
    logic [23:0] probe_rgb;
    logic        frame_done, locked, geom_err;

    vga_frame_monitor #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n), .rgb(rgb),
        .probe_x(probe_x), .probe_y(probe_y),
        .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
        .h_active_meas(h_active_meas), .v_active_meas(v_active_meas),
        .frame_sum(frame_sum), .probe_rgb(probe_rgb),
        .frame_done(frame_done), .locked(locked), .geom_err(geom_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int base;
    bit half = 1'b0;
    int sum_prev = 0, sum_prev2 = 0;
    logic [23:0] probe_prev = '0, probe_prev2 = '0;
    logic [31:0] sum_full;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rx_x"}, 32'(rx_x), 0);
        chk({tag, ".rx_y"}, 32'(rx_y), 0);
        chk({tag, ".rx_valid"}, 32'(rx_valid), 0);
        chk({tag, ".h_total"}, 32'(h_total_meas), 0);
        chk({tag, ".v_total"}, 32'(v_total_meas), 0);
        chk({tag, ".h_active"}, 32'(h_active_meas), 0);
        chk({tag, ".v_active"}, 32'(v_active_meas), 0);
        chk({tag, ".frame_sum"}, frame_sum, 0);
        chk({tag, ".probe_rgb"}, 32'(probe_rgb), 0);
        chk({tag, ".frame_done"}, 32'(frame_done), 0);
        chk({tag, ".locked"}, 32'(locked), 0);
        chk({tag, ".geom_err"}, 32'(geom_err), 0);
    endtask

    task automatic chk_geom(input string tag, input int ht, input int lk);
        chk({tag, ".h_total"}, 32'(h_total_meas), 32'(ht));
        chk({tag, ".v_total"}, 32'(v_total_meas), VT);
        chk({tag, ".h_active"}, 32'(h_active_meas), HA);
        chk({tag, ".v_active"}, 32'(v_active_meas), VA);
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
        chk({tag, ".geom_err"}, 32'(geom_err), 32'(lk == 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pix(input logic hs, input logic vs, input logic bl, input logic [23:0] c);
        hsync_n = hs;
        vsync_n = vs;
        blank_n = bl;
        rgb     = c;
        pix_en  = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        if (half) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: 0x010203 active, 0xFFFFFF blanked; mode 1: single 0xABCDEF at
    // active (15,11), black elsewhere; mode 2: position-dependent pattern.
    task automatic send_frame(input int hlen, input bit coinc, input int mode,
                              input int stop_line, input bit chk_xy);
        int a0, hs0, x, y, fsum;
        bit act;
        logic [23:0] c, fprobe;
        a0 = coinc ? 6 : 0;
        hs0 = coinc ? 0 : 18;
        fsum = 0;
        fprobe = '0;
        for (int v = 0; v < VT; v++) begin
            if (v == stop_line) return;
            for (int h = 0; h < hlen; h++) begin
                act = (v >= 3) && (v < 3 + VA) && (h >= a0) && (h < a0 + HA);
                x = h - a0;
                y = v - 3;
                case (mode)
                    0:       c = act ? 24'h010203 : 24'hFFFFFF;
                    1:       c = (act && x == 15 && y == 11) ? 24'hABCDEF : 24'h000000;
                    default: c = {8'(h * 7), 8'(v * 13), 8'(h + v)};
                endcase
                if (act) begin
                    fsum += int'(c[23:16]) + int'(c[15:8]) + int'(c[7:0]);
                    if (x == int'(probe_x) && y == int'(probe_y)) fprobe = c;
                end
                pix(!(h >= hs0 && h < hs0 + 4), !(v < 2), act, c);
                if (chk_xy && act && x == 5 && y == 1) begin
                    chk("rx_x@5,1", 32'(rx_x), 5);
                    chk("rx_y@5,1", 32'(rx_y), 1);
                    chk("rx_valid@5,1", 32'(rx_valid), 1);
                end
                if (chk_xy && v == 4 && h == a0 + HA)
                    chk("rx_valid_blank", 32'(rx_valid), 0);
            end
        end
        sum_prev2 = sum_prev;
        sum_prev = fsum;
        probe_prev2 = probe_prev;
        probe_prev = fprobe;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk_zero("reset");
        do_reset();

        // Ideal raster, constant color, probe outside active area
        probe_x = 10'd20; probe_y = 10'd5;
        base = done_cnt;
        send_frame(HT, 0, 0, -1, 1);
        chk("ideal.no_done_first_vedge", 32'(done_cnt - base), 0);
        send_frame(HT, 0, 0, -1, 0);
        chk("ideal.done_count", 32'(done_cnt - base), 1);
        chk_geom("ideal", HT, 1);
        chk("ideal.frame_sum", frame_sum, 32'd1152);
        chk("ideal.probe_outside", 32'(probe_rgb), 0);

        // Probe at bottom-right active pixel with a unique color
        probe_x = 10'd15; probe_y = 10'd11;
        send_frame(HT, 0, 1, -1, 0);
        send_frame(HT, 0, 1, -1, 0);
        chk("probe.probe_rgb", 32'(probe_rgb), 32'hABCDEF);
        chk("probe.frame_sum", frame_sum, 32'd615);
        chk("probe.locked", 32'(locked), 1);

        // Short lines after a locked frame, then restored
        send_frame(HT - 1, 0, 0, -1, 0);
        send_frame(HT, 0, 0, -1, 0);
        chk_geom("short", HT - 1, 0);
        chk("short.frame_sum", frame_sum, 32'd1152);
        send_frame(HT, 0, 0, -1, 0);
        chk_geom("restored", HT, 1);

        // Full-rate vs half-rate strobes with a varied pattern
        probe_x = 10'd3; probe_y = 10'd7;
        do_reset();
        half = 1'b0;
        send_frame(HT, 0, 2, -1, 0);
        send_frame(HT, 0, 2, -1, 0);
        chk_geom("full", HT, 1);
        chk("full.frame_sum", frame_sum, 32'(sum_prev2));
        chk("full.probe_rgb", 32'(probe_rgb), 32'(probe_prev2));
        sum_full = frame_sum;
        do_reset();
        half = 1'b1;
        base = done_cnt;
        send_frame(HT, 0, 2, -1, 1);
        send_frame(HT, 0, 2, -1, 0);
        chk("half.done_pulse_count", 32'(done_cnt - base), 1);
        chk_geom("half", HT, 1);
        chk("half.frame_sum", frame_sum, 32'(sum_prev2));
        chk("half.same_as_full", frame_sum, sum_full);
        chk("half.probe_rgb", 32'(probe_rgb), 32'(probe_prev2));
        half = 1'b0;

        // Reset mid-frame
        do_reset();
        send_frame(HT, 0, 0, -1, 0);
        send_frame(HT, 0, 0, -1, 0);
        chk("midrst.locked_before", 32'(locked), 1);
        send_frame(HT, 0, 0, 9, 0);
        rst = 1'b1;
        #1;
        chk("midrst.locked_async", 32'(locked), 0);
        @(posedge clk);
        #1;
        chk_zero("midrst");
        rst = 1'b0;
        base = done_cnt;
        send_frame(HT, 0, 0, -1, 0);
        chk("midrst.no_done_after_1", 32'(done_cnt - base), 0);
        chk("midrst.h_total_still0", 32'(h_total_meas), 0);
        send_frame(HT, 0, 0, -1, 0);
        chk("midrst.done_after_2", 32'(done_cnt - base), 1);
        chk_geom("midrst", HT, 1);

        // Coincident H-edge and V-edge
        do_reset();
        base = done_cnt;
        send_frame(HT, 1, 0, -1, 0);
        send_frame(HT, 1, 0, -1, 0);
        chk_geom("coinc1", HT, 1);
        chk("coinc1.frame_sum", frame_sum, 32'd1152);
        send_frame(HT, 1, 0, -1, 0);
        chk_geom("coinc2", HT, 1);
        chk("coinc.done_count", 32'(done_cnt - base), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
